fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: address and instruction width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears all state immediately, release takes effect synchronously to clk.
REQ-005 imem_addr  output  XLEN  byte address presented to the synchronous instruction memory (read data returns one cycle later).
REQ-006 imem_en  output  1  high in a cycle when a fetch request is issued at imem_addr.
REQ-007 imem_rdata  input  XLEN  instruction word for the address issued in the previous cycle.
REQ-008 redirect_valid  input  1  branch/jump taken; overrides all other activity this cycle.
REQ-009 redirect_pc  input  XLEN  new fetch target; bits [1:0] ignored and treated as 0.
REQ-010 ready_in  input  1  decode stage accepts the current output word.
REQ-011 valid_out  output  1  instr_out/pc_out hold a valid fetched instruction.
REQ-012 instr_out  output  XLEN  fetched instruction.
REQ-013 pc_out  output  XLEN  address of instr_out.

Function
REQ-014 Internal state: pc_q (next issue address), req_valid_q/req_pc_q (request in flight), one-entry skid buffer (skid_valid, skid_instr, skid_pc), output register.
REQ-015 imem_addr SHALL equal pc_q combinationally; imem_en = issue_en.
REQ-016 issue_en = !redirect_valid && !skid_valid && !(req_valid_q && valid_out && !ready_in).
REQ-017 On issue: pc_q <= pc_q + 4 (modulo 2^XLEN, wraps 0xFFFF_FFFC -> 0), req_valid_q <= 1, req_pc_q <= pc_q; otherwise req_valid_q <= 0 and pc_q holds.
REQ-018 Transfer occurs when valid_out && ready_in.
REQ-019 Output load priority when output is empty or transferring: skid entry first, else in-flight response (imem_rdata, req_pc_q), else valid_out <= 0.
REQ-020 In-flight response arriving while output held (valid_out && !ready_in) SHALL be written to the skid buffer; no response is ever dropped or duplicated outside redirect.
REQ-021 Skid entry moves to output on transfer; an in-flight response arriving the same cycle fills the freed skid slot (never possible given REQ-016, checked by assertion).
REQ-022 Steady-state latency: address issued in cycle n appears on valid_out in cycle n+2; throughput one instruction per cycle with ready_in held high.
REQ-023 Redirect in cycle t: valid_out, skid_valid, req_valid_q cleared at edge t; pc_q <= {redirect_pc[XLEN-1:2],2'b00}; in-flight response discarded; first target issued in t+1, valid_out in t+3.
REQ-024 Redirect and ready_in in the same cycle: the current output word counts as transferred; redirect still flushes.
REQ-025 instr_out/pc_out SHALL hold stable while valid_out && !ready_in.

Reset
REQ-026 While reset low: pc_q = RESET_PC, valid_out = 0, instr_out = 0, pc_out = 0, skid_valid = 0, req_valid_q = 0, imem_en = 0.
REQ-027 First issue at RESET_PC in the first clk edge cycle after reset release; reset asserted mid-operation discards all in-flight and buffered words.

Structure
REQ-028 Shared package riscv_pkg holds XLEN, ILEN, RESET_PC default, and NOP constant 32'h0000_0013.
REQ-029 Skid buffer implemented as sub-module fetch_skid_buffer (one entry: data, pc, valid, load/unload); PC logic and output register stay in fetch_unit.
REQ-030 Assertion: skid_valid and incoming response with held output never coincide.

Verification
REQ-031 Reset release, ready_in=1, memory word = address: imem_addr 0,4,8...; valid_out from cycle 3 with pc_out=instr_out=0,4,8 consecutively.
REQ-032 ready_in low for 3 cycles mid-stream: no gaps/duplicates, pc_out sequence unbroken, imem_en low while skid full, output stable while stalled.
REQ-033 redirect_valid with redirect_pc=0x100 at cycle t: valid_out low t+1..t+2, pc_out=0x100 at t+3, then 0x104.
REQ-034 redirect_pc=0x203: fetch begins at 0x200.
REQ-035 RESET_PC=0xFFFF_FFF8, free-running: pc_out FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 reset asserted while stalled with skid full: all outputs 0 immediately; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core-wide constants.
// Datapath width, reset vector and canonical NOP.
package riscv_pkg;

  localparam int          XLEN     = 32;
  localparam int          ILEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for fetch responses.
// Catches a memory word that arrives while decode is stalled.
module fetch_skid_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Load wins over unload so a freed slot can refill in the same cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, sync imem
// request, skid buffering and the decode-facing register.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_en,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            ready_in,
  output logic            valid_out,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            req_valid_q, req_valid_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pco_q, pco_d;

  logic            hold;
  logic            resp;
  logic            issue_en;
  logic            skid_valid;
  logic            skid_load;
  logic            skid_unload;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;

  always_comb begin
    hold        = valid_q && !ready_in;
    resp        = req_valid_q && !redirect_valid;
    issue_en    = reset && !redirect_valid && !skid_valid
                  && !(req_valid_q && hold);
    skid_load   = resp && (hold || skid_valid);
    skid_unload = !redirect_valid && !hold && skid_valid;

    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = issue_en;
    valid_d     = valid_q;
    instr_d     = instr_q;
    pco_d       = pco_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc & ~XLEN'(3);
      valid_d = 1'b0;
    end else begin
      if (issue_en) begin
        pc_d     = pc_q + XLEN'(4);
        req_pc_d = pc_q;
      end
      // Output is free or draining: oldest word first.
      if (!hold) begin
        if (skid_valid) begin
          valid_d = 1'b1;
          instr_d = skid_instr;
          pco_d   = skid_pc;
        end else if (resp) begin
          valid_d = 1'b1;
          instr_d = imem_rdata;
          pco_d   = req_pc_q;
        end else begin
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      pco_q       <= '0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pco_q       <= pco_d;
    end
  end

  fetch_skid_buffer #(
    .XLEN (XLEN)
  ) u_skid (
    .clk_i    (clk),
    .rst_ni   (reset),
    .flush_i  (redirect_valid),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (imem_rdata),
    .pc_i     (req_pc_q),
    .valid_o  (skid_valid),
    .data_o   (skid_instr),
    .pc_o     (skid_pc)
  );

  assign imem_addr = pc_q;
  assign imem_en   = issue_en;
  assign valid_out = valid_q;
  assign instr_out = instr_q;
  assign pc_out    = pco_q;

  // Issue throttling must keep a response from meeting a full skid slot.
  a_no_skid_overrun : assert property (
    @(posedge clk) disable iff (!reset)
    !(skid_valid && req_valid_q && hold)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall,
// redirect, PC wrap and reset-while-stalled.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        ready_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] imem_addr, imem_rdata, instr_out, pc_out;
  logic        imem_en, valid_out;

  logic [31:0] imem_addr2, imem_rdata2, instr_out2, pc_out2;
  logic        imem_en2, valid_out2;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ready_in       (ready_in),
    .valid_out      (valid_out),
    .instr_out      (instr_out),
    .pc_out         (pc_out)
  );

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr2),
    .imem_en        (imem_en2),
    .imem_rdata     (imem_rdata2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .ready_in       (1'b1),
    .valid_out      (valid_out2),
    .instr_out      (instr_out2),
    .pc_out         (pc_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word equals its own address, one-cycle read latency.
  always @(posedge clk) begin
    imem_rdata  <= imem_addr;
    imem_rdata2 <= imem_addr2;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    ready_in       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_en", 32'(imem_en), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);

    reset = 1'b1;
    #1;
    chk("c0_en", 32'(imem_en), 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    step();
    chk("c1_addr", imem_addr, 32'h4);
    chk("c1_valid", 32'(valid_out), 32'd0);
    step();
    chk("c2_valid", 32'(valid_out), 32'd1);
    chk("c2_pc", pc_out, 32'h0);
    chk("c2_instr", instr_out, 32'h0);
    chk("c2_addr", imem_addr, 32'h8);
    chk("w2_pc", pc_out2, 32'hFFFF_FFF8);
    chk("w2_addr", imem_addr2, 32'h0);
    step();
    chk("c3_pc", pc_out, 32'h4);
    chk("c3_instr", instr_out, 32'h4);
    chk("w3_pc", pc_out2, 32'hFFFF_FFFC);
    step();
    chk("c4_pc", pc_out, 32'h8);
    chk("w4_pc", pc_out2, 32'h0000_0000);
    chk("w4_instr", instr_out2, 32'h0000_0000);
    chk("w4_valid", 32'(valid_out2), 32'd1);

    ready_in = 1'b0;
    #1;
    chk("c4_en_stall", 32'(imem_en), 32'd0);
    step();
    chk("c5_valid", 32'(valid_out), 32'd1);
    chk("c5_pc", pc_out, 32'h8);
    chk("c5_instr", instr_out, 32'h8);
    chk("c5_en", 32'(imem_en), 32'd0);
    step();
    chk("c6_pc", pc_out, 32'h8);
    chk("c6_en", 32'(imem_en), 32'd0);
    step();
    ready_in = 1'b1;
    #1;
    chk("c7_pc", pc_out, 32'h8);
    chk("c7_en", 32'(imem_en), 32'd0);
    step();
    chk("c8_pc", pc_out, 32'hC);
    chk("c8_instr", instr_out, 32'hC);
    chk("c8_en", 32'(imem_en), 32'd1);
    chk("c8_addr", imem_addr, 32'h10);
    step();
    chk("c9_valid", 32'(valid_out), 32'd0);
    step();
    chk("c10_pc", pc_out, 32'h10);
    chk("c10_valid", 32'(valid_out), 32'd1);
    step();
    chk("c11_pc", pc_out, 32'h14);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("rd_en", 32'(imem_en), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rd1_valid", 32'(valid_out), 32'd0);
    chk("rd1_addr", imem_addr, 32'h100);
    chk("rd1_en", 32'(imem_en), 32'd1);
    step();
    chk("rd2_valid", 32'(valid_out), 32'd0);
    step();
    chk("rd3_valid", 32'(valid_out), 32'd1);
    chk("rd3_pc", pc_out, 32'h100);
    chk("rd3_instr", instr_out, 32'h100);
    step();
    chk("rd4_pc", pc_out, 32'h104);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("ra1_addr", imem_addr, 32'h200);
    chk("ra1_valid", 32'(valid_out), 32'd0);
    step();
    chk("ra2_valid", 32'(valid_out), 32'd0);
    step();
    chk("ra3_pc", pc_out, 32'h200);
    step();
    chk("ra4_pc", pc_out, 32'h204);

    ready_in = 1'b0;
    step();
    chk("sk_pc", pc_out, 32'h204);
    chk("sk_en", 32'(imem_en), 32'd0);
    reset = 1'b0;
    #1;
    chk("mr_valid", 32'(valid_out), 32'd0);
    chk("mr_pc", pc_out, 32'h0);
    chk("mr_instr", instr_out, 32'h0);
    chk("mr_en", 32'(imem_en), 32'd0);
    chk("mr_addr", imem_addr, 32'h0);
    step();
    step();
    reset    = 1'b1;
    ready_in = 1'b1;
    #1;
    chk("rr0_en", 32'(imem_en), 32'd1);
    chk("rr0_addr", imem_addr, 32'h0);
    step();
    chk("rr1_valid", 32'(valid_out), 32'd0);
    step();
    chk("rr2_valid", 32'(valid_out), 32'd1);
    chk("rr2_pc", pc_out, 32'h0);
    step();
    chk("rr3_pc", pc_out, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
